// File: rtl/frame_counter_hdr_pkg.sv
// Shared encodings and frame-length constants for the I3C frame counter.
package fcnt_pkg;

  // i_fcnt_mode encodings
  localparam logic FCNT_SDR = 1'b0;
  localparam logic FCNT_DDR = 1'b1;

  // i_fcnt_dir encodings
  localparam logic FCNT_RX = 1'b0;
  localparam logic FCNT_TX = 1'b1;

  // Bus bits per frame: SDR = 8 data + T-bit, HDR-DDR = 2 preamble + 16 payload + 2 parity
  localparam int SDR_FRM_BITS = 9;
  localparam int DDR_FRM_BITS = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fcnt_state_t;

endpackage

// File: rtl/frame_counter_hdr_bit_counter.sv
// Bit index within a frame; wraps to zero after the last bit of the frame.
module frame_bit_counter
  import fcnt_pkg::*;
#(
  parameter int BIT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [BIT_W-1:0] i_frm_len,
  output logic [BIT_W-1:0] o_bit_idx,
  output logic             o_wrap
);

  logic [BIT_W-1:0] r_bit_idx;
  logic [BIT_W-1:0] w_last_bit;

  assign w_last_bit = i_frm_len - BIT_W'(1);
  // Wrap is combinational so the parent can register frame_end on the same edge.
  assign o_wrap     = i_enable && (r_bit_idx == w_last_bit);
  assign o_bit_idx  = r_bit_idx;

  // Count enabled bits, holding between strobes; clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx <= '0;
    end else if (i_clear) begin
      r_bit_idx <= '0;
    end else if (i_enable) begin
      r_bit_idx <= o_wrap ? '0 : r_bit_idx + BIT_W'(1);
    end
  end

endmodule

// File: rtl/frame_counter_hdr.sv
// Frame counter for the SDR / HDR-DDR bit engines.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; bit strobes ignored
//   RUN   | counting bits into frames until the final frame completes
//   DONE  | single cycle after completion; busy/last_frame still high
//
// The frame total is latched in CNT_W+1 bits so RX with no_frms = 255
// (header frame included) yields 256 frames without overflow.
module frame_counter_hdr
  import fcnt_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int SDR_FRM_BITS = fcnt_pkg::SDR_FRM_BITS,
  parameter int DDR_FRM_BITS = fcnt_pkg::DDR_FRM_BITS
) (
  input  logic                              i_fcnt_clk,
  input  logic                              i_fcnt_rst_n,
  input  logic                              i_fcnt_start,
  input  logic                              i_fcnt_abort,
  input  logic [CNT_W-1:0]                  i_fcnt_no_frms,
  input  logic                              i_fcnt_mode,
  input  logic                              i_fcnt_dir,
  input  logic                              i_fcnt_bit_en,
  output logic                              o_fcnt_busy,
  output logic [$clog2(DDR_FRM_BITS)-1:0]   o_fcnt_bit_cnt,
  output logic [CNT_W-1:0]                  o_fcnt_frm_cnt,
  output logic                              o_fcnt_frame_end,
  output logic                              o_fcnt_last_frame,
  output logic                              o_fcnt_done,
  output logic                              o_fcnt_err
);

  localparam int BIT_W = $clog2(DDR_FRM_BITS);

  fcnt_state_t      r_state;
  logic             r_mode;
  logic [CNT_W:0]   r_total;
  logic [CNT_W-1:0] r_frm_cnt;
  logic             r_busy;
  logic             r_last_frame;
  logic             r_frame_end;
  logic             r_done;
  logic             r_err;

  logic [CNT_W:0]   w_total_in;
  logic [CNT_W:0]   w_last_idx;
  logic [CNT_W-1:0] w_frm_nxt;
  logic             w_is_last;
  logic [BIT_W-1:0] w_frm_len;
  logic             w_bit_clear;
  logic             w_bit_enable;
  logic             w_wrap;

  // RX counts the header frame on top of the programmed payload frames.
  assign w_total_in   = {1'b0, i_fcnt_no_frms}
                      + {{CNT_W{1'b0}}, (i_fcnt_dir == FCNT_RX)};
  assign w_last_idx   = r_total - {{CNT_W{1'b0}}, 1'b1};
  assign w_is_last    = ({1'b0, r_frm_cnt} == w_last_idx);
  assign w_frm_nxt    = r_frm_cnt + CNT_W'(1);
  assign w_frm_len    = (r_mode == FCNT_DDR) ? BIT_W'(DDR_FRM_BITS) : BIT_W'(SDR_FRM_BITS);

  // Abort must suppress a frame completing in the same cycle.
  assign w_bit_enable = i_fcnt_bit_en && (r_state == RUN) && !i_fcnt_abort;
  assign w_bit_clear  = i_fcnt_abort || (r_state != RUN);

  frame_bit_counter #(
    .BIT_W (BIT_W)
  ) u_bit_cnt (
    .i_clk     (i_fcnt_clk),
    .i_rst_n   (i_fcnt_rst_n),
    .i_clear   (w_bit_clear),
    .i_enable  (w_bit_enable),
    .i_frm_len (w_frm_len),
    .o_bit_idx (o_fcnt_bit_cnt),
    .o_wrap    (w_wrap)
  );

  // Sequencing FSM with frame index, latched config and registered flags.
  always_ff @(posedge i_fcnt_clk or negedge i_fcnt_rst_n) begin
    if (!i_fcnt_rst_n) begin
      r_state      <= IDLE;
      r_mode       <= FCNT_SDR;
      r_total      <= '0;
      r_frm_cnt    <= '0;
      r_busy       <= 1'b0;
      r_last_frame <= 1'b0;
      r_frame_end  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_end <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      if (i_fcnt_abort) begin
        r_state      <= IDLE;
        r_frm_cnt    <= '0;
        r_busy       <= 1'b0;
        r_last_frame <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_fcnt_start) begin
              if (w_total_in == '0) begin
                r_err <= 1'b1;
              end else begin
                r_state      <= RUN;
                r_mode       <= i_fcnt_mode;
                r_total      <= w_total_in;
                r_frm_cnt    <= '0;
                r_busy       <= 1'b1;
                r_last_frame <= (w_total_in == {{CNT_W{1'b0}}, 1'b1});
              end
            end
          end
          RUN: begin
            if (w_wrap) begin
              r_frame_end <= 1'b1;
              if (w_is_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_frm_cnt    <= w_frm_nxt;
                r_last_frame <= ({1'b0, w_frm_nxt} == w_last_idx);
              end
            end
          end
          DONE: begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_last_frame <= 1'b0;
          end
          default: begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_last_frame <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_fcnt_busy       = r_busy;
  assign o_fcnt_frm_cnt    = r_frm_cnt;
  assign o_fcnt_frame_end  = r_frame_end;
  assign o_fcnt_last_frame = r_last_frame;
  assign o_fcnt_done       = r_done;
  assign o_fcnt_err        = r_err;

endmodule

// File: tb/tb_frame_counter_hdr.sv
// Bench for frame_counter_hdr: arithmetic reference model plus directed scenarios.
module tb_frame_counter_hdr;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_abort;
  logic [7:0] i_no_frms;
  logic       i_mode;
  logic       i_dir;
  logic       i_bit_en;
  logic       o_busy;
  logic [4:0] o_bit_cnt;
  logic [7:0] o_frm_cnt;
  logic       o_frame_end;
  logic       o_last_frame;
  logic       o_done;
  logic       o_err;

  frame_counter_hdr dut (
    .i_fcnt_clk        (clk),
    .i_fcnt_rst_n      (rst_n),
    .i_fcnt_start      (i_start),
    .i_fcnt_abort      (i_abort),
    .i_fcnt_no_frms    (i_no_frms),
    .i_fcnt_mode       (i_mode),
    .i_fcnt_dir        (i_dir),
    .i_fcnt_bit_en     (i_bit_en),
    .o_fcnt_busy       (o_busy),
    .o_fcnt_bit_cnt    (o_bit_cnt),
    .o_fcnt_frm_cnt    (o_frm_cnt),
    .o_fcnt_frame_end  (o_frame_end),
    .o_fcnt_last_frame (o_last_frame),
    .o_fcnt_done       (o_done),
    .o_fcnt_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: total bits seen since start, frame total, frame length.
  int m_busy, m_fin, m_bits, m_T, m_fb, m_t;
  int e_frm, e_fe, e_done, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_fin = 0; m_bits = 0; m_T = 0; m_fb = 9;
      e_frm = 0; e_fe = 0; e_done = 0; e_err = 0;
    end else begin
      e_fe = 0; e_done = 0; e_err = 0;
      if (i_abort) begin
        m_busy = 0; m_fin = 0; m_bits = 0; e_frm = 0;
      end else if (m_busy == 0) begin
        if (i_start) begin
          m_t = int'(i_no_frms) + (i_dir ? 0 : 1);
          if (m_t == 0) e_err = 1;
          else begin
            m_busy = 1; m_fin = 0; m_T = m_t; m_fb = i_mode ? 20 : 9;
            m_bits = 0; e_frm = 0;
          end
        end
      end else if (m_fin != 0) begin
        m_busy = 0; m_fin = 0;
      end else if (i_bit_en) begin
        m_bits = m_bits + 1;
        if (m_bits % m_fb == 0) begin
          e_fe = 1;
          if (m_bits == m_T * m_fb) begin
            e_done = 1; m_fin = 1;
          end
        end
      end
      if (m_busy != 0)
        e_frm = (m_bits / m_fb < m_T - 1) ? m_bits / m_fb : m_T - 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cnt_fe = 0, cnt_done = 0, cnt_err = 0, max_frm = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int e_last;
    e_last = (m_busy != 0 && e_frm == m_T - 1) ? 1 : 0;
    chk("busy",       int'(o_busy),       m_busy);
    chk("bit_cnt",    int'(o_bit_cnt),    m_bits % m_fb);
    chk("frm_cnt",    int'(o_frm_cnt),    e_frm);
    chk("frame_end",  int'(o_frame_end),  e_fe);
    chk("last_frame", int'(o_last_frame), e_last);
    chk("done",       int'(o_done),       e_done);
    chk("err",        int'(o_err),        e_err);
    cnt_fe   += int'(o_frame_end);
    cnt_done += int'(o_done);
    cnt_err  += int'(o_err);
    if (int'(o_frm_cnt) > max_frm) max_frm = int'(o_frm_cnt);
  endtask

  // One clock: inputs apply at posedge, outputs checked at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic start(input int nf, input logic mode, input logic dir);
    i_no_frms = 8'(nf); i_mode = mode; i_dir = dir; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic strobes(input int n, input int gap, input bit rnd);
    int g;
    for (int i = 0; i < n; i++) begin
      i_bit_en = 1'b1;
      tick();
      i_bit_en = 1'b0;
      g = rnd ? int'($urandom_range(0, 2)) : gap;
      repeat (g) tick();
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (o_busy && k < bound) begin
      tick();
      k++;
    end
    chk("idle_timeout", int'(o_busy), 0);
  endtask

  int fe0, d0, er0;

  initial begin
    rst_n = 1'b0; i_start = 0; i_abort = 0; i_no_frms = 0;
    i_mode = 0; i_dir = 0; i_bit_en = 0;
    tick(); tick();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_frm", int'(o_frm_cnt), 0);
    rst_n = 1'b1;
    tick();

    // TX SDR, 3 frames back-to-back
    fe0 = cnt_fe; d0 = cnt_done;
    start(3, 1'b0, 1'b1);
    chk("t1_busy", int'(o_busy), 1);
    chk("t1_last0", int'(o_last_frame), 0);
    strobes(18, 0, 0);
    chk("t1_fe18", int'(o_frame_end), 1);
    chk("t1_last18", int'(o_last_frame), 1);
    chk("t1_frm18", int'(o_frm_cnt), 2);
    strobes(9, 0, 0);
    chk("t1_done27", int'(o_done), 1);
    chk("t1_fe27", int'(o_frame_end), 1);
    tick();
    chk("t1_busy_off", int'(o_busy), 0);
    chk("t1_fe_cnt", cnt_fe - fe0, 3);
    chk("t1_done_cnt", cnt_done - d0, 1);

    // RX DDR, no_frms=2 -> 3 frames; start in the first IDLE cycle after DONE
    fe0 = cnt_fe; d0 = cnt_done;
    start(2, 1'b1, 1'b0);
    chk("t2_busy", int'(o_busy), 1);
    strobes(59, 1, 0);
    chk("t2_done_early", cnt_done - d0, 0);
    strobes(1, 0, 0);
    chk("t2_done", int'(o_done), 1);
    chk("t2_frm", int'(o_frm_cnt), 2);
    wait_idle(10);
    chk("t2_fe_cnt", cnt_fe - fe0, 3);

    // TX with zero frames -> error pulse only
    er0 = cnt_err;
    start(0, 1'b0, 1'b1);
    chk("t3_err", int'(o_err), 1);
    chk("t3_busy", int'(o_busy), 0);
    tick(); tick();
    chk("t3_err_cnt", cnt_err - er0, 1);

    // RX SDR, no_frms=0 -> single header frame
    d0 = cnt_done;
    start(0, 1'b0, 1'b0);
    chk("t4_last", int'(o_last_frame), 1);
    strobes(9, 0, 0);
    chk("t4_done", int'(o_done), 1);
    wait_idle(10);

    // start and abort together in IDLE -> stays idle
    i_abort = 1'b1;
    start(5, 1'b0, 1'b1);
    i_abort = 1'b0;
    chk("t5a_busy", int'(o_busy), 0);

    // TX SDR 4 frames, abort coincident with the 14th strobe
    d0 = cnt_done;
    start(4, 1'b0, 1'b1);
    strobes(13, 0, 0);
    i_abort = 1'b1; i_bit_en = 1'b1;
    tick();
    i_abort = 1'b0; i_bit_en = 1'b0;
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_bit", int'(o_bit_cnt), 0);
    chk("t5_frm", int'(o_frm_cnt), 0);
    tick();
    chk("t5_no_done", cnt_done - d0, 0);
    start(1, 1'b0, 1'b1);
    strobes(9, 0, 0);
    chk("t5_done2", int'(o_done), 1);
    wait_idle(10);

    // Abort on the strobe that would finish the final frame
    d0 = cnt_done; fe0 = cnt_fe;
    start(1, 1'b0, 1'b1);
    strobes(8, 0, 0);
    i_abort = 1'b1; i_bit_en = 1'b1;
    tick();
    i_abort = 1'b0; i_bit_en = 1'b0;
    tick();
    chk("t5b_no_fe", cnt_fe - fe0, 0);
    chk("t5b_no_done", cnt_done - d0, 0);

    // RX SDR 255 -> 256 frames, random gaps, start+mode toggle mid-run ignored
    d0 = cnt_done; max_frm = 0;
    start(255, 1'b0, 1'b0);
    strobes(1000, 0, 1);
    i_start = 1'b1; i_mode = 1'b1; i_no_frms = 8'd3;
    tick();
    i_start = 1'b0;
    strobes(1303, 0, 1);
    chk("t6_busy", int'(o_busy), 1);
    chk("t6_done_early", cnt_done - d0, 0);
    strobes(1, 0, 0);
    chk("t6_done", int'(o_done), 1);
    chk("t6_frm", int'(o_frm_cnt), 255);
    wait_idle(10);
    chk("t6_max_frm", max_frm, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_counter_hdr.md
Name: frame_counter_hdr

Overview:
Parametrised frame counter for the I3C controller bit engines. It counts bus bits into frames for SDR (9-bit frames: 8 data + T-bit) and HDR-DDR (20-bit words: 2 preamble + 16 payload + 2 parity). It tracks frames against a programmed total, with TX/RX direction handling, and flags frame boundaries, the last frame, completion and configuration errors. It sits between the controller FSM and the SDR/DDR TX and RX shift engines, and is clocked by the system clock; bit enables arrive as strobes.

Parameters:
CNT_W, 8, width of frame-count input and frame index output.
SDR_FRM_BITS, 9, bits per SDR frame.
DDR_FRM_BITS, 20, bits per HDR-DDR word.
BIT_W, $clog2(DDR_FRM_BITS), bit-index width (derived, not overridden).

Ports:
i_fcnt_clk  in  1  system clock, rising edge.
i_fcnt_rst_n  in  1  asynchronous active-low reset.
i_fcnt_start  in  1  one-cycle pulse; samples config and starts a count.
i_fcnt_abort  in  1  one-cycle pulse; cancels the count.
i_fcnt_no_frms  in  CNT_W  programmed frame count.
i_fcnt_mode  in  1  0 = SDR, 1 = HDR-DDR.
i_fcnt_dir  in  1  0 = RX, 1 = TX.
i_fcnt_bit_en  in  1  one-cycle strobe per bus bit.
o_fcnt_busy  out  1  high while counting.
o_fcnt_bit_cnt  out  BIT_W  bit index within the current frame.
o_fcnt_frm_cnt  out  CNT_W  index of the current frame.
o_fcnt_frame_end  out  1  one-cycle pulse per completed frame.
o_fcnt_last_frame  out  1  level; high while the final frame is in progress.
o_fcnt_done  out  1  one-cycle pulse at completion.
o_fcnt_err  out  1  one-cycle pulse on invalid start.

Behaviour:
- Clock and reset: single clock i_fcnt_clk; asynchronous active-low reset i_fcnt_rst_n. All registers and outputs reset to 0; state resets to IDLE.
- Frame total T:
  - TX: T = no_frms.
  - RX: T = no_frms + 1, because RX also counts the header frame.
  - T is held in a CNT_W+1-bit register, so RX with 255 gives T = 256 without overflow.
- Frame length FB: SDR_FRM_BITS when mode = 0, DDR_FRM_BITS when mode = 1. mode, dir and no_frms are latched at start; changes mid-run are ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - bit_en is ignored.
  - start with T = 0 (TX and no_frms = 0): err pulses next cycle; state stays IDLE.
  - start with T ≥ 1: go to RUN next cycle; bit_cnt and frm_cnt = 0; busy = 1.
  - last_frame = 1 immediately if T = 1.
- RUN:
  - Each bit_en increments bit_cnt.
  - A bit_en with bit_cnt = FB-1 wraps bit_cnt to 0 and pulses frame_end on the next cycle (registered, 1-cycle latency).
  - If that frame was not the last: frm_cnt increments. last_frame sets in the same cycle frm_cnt becomes T-1.
  - If frm_cnt = T-1: go to DONE. done pulses coincident with that final frame_end. frm_cnt holds T-1.
- DONE: one cycle. Clear busy and last_frame, then return to IDLE. done has already been issued.
- start while busy (RUN or DONE): ignored, no error.
- abort in any state: next cycle go to IDLE with all counters and flags cleared. No done or frame_end is issued, even if bit_en completes a frame in the same cycle (abort wins).
- start and abort in the same cycle: abort wins; stay IDLE.
- A new start is legal in the cycle immediately after DONE returns to IDLE.
- Gaps between bit_en strobes are arbitrary; counters hold between strobes.
- Unlike the old counter, the frame index is full CNT_W wide, so any no_frms is counted correctly.

Decomposition:
- Package fcnt_pkg holds:
  - mode encodings FCNT_SDR / FCNT_DDR;
  - direction encodings FCNT_RX / FCNT_TX;
  - state enum fcnt_state_t {IDLE, RUN, DONE};
  - frame-length constants SDR_FRM_BITS = 9 and DDR_FRM_BITS = 20.
- One sub-module, frame_bit_counter:
  - inputs: clear, enable, frame length;
  - outputs: bit index and a wrap strobe.
- The top level owns the FSM, the frame index, total computation and flags.

Test Plan:
- TX, SDR, no_frms = 3, 27 bit_en strobes → frame_end one cycle after strobes 9, 18 and 27. last_frame rises after strobe 18. done coincides with the third frame_end. busy = 0 two cycles after strobe 27.
- RX, DDR, no_frms = 2 (T = 3), 60 strobes → frame_end after strobes 20, 40 and 60. frm_cnt steps 0→1→2. done after strobe 60.
- TX, no_frms = 0 → err pulses once; busy stays 0.
- RX, SDR, no_frms = 0 (T = 1) → last_frame high from the first RUN cycle; done after 9 strobes.
- TX, SDR, no_frms = 4, abort after 13 strobes, with a 14th bit_en in the same cycle → busy, bit_cnt and frm_cnt are 0 next cycle; no done. A following start with no_frms = 1 completes after 9 strobes.
- RX, SDR, no_frms = 255 with random bit_en gaps, plus a start pulse and a mode toggle mid-run → both ignored. frm_cnt reaches 255 with no wrap; done after exactly 2304 strobes.
